cache_ctrl_coherent: RTL and testbench

- Parametrised successor of the single-line cache controller; sits between the CPU request port, the cache datapath (tag/state lookup) and the ACE controller.
- Adds over the previous generation:
  - valid/ready request handshake with a latched opcode
  - explicit state-write strobe
  - dirty-victim writeback followed by refill and re-lookup
  - SC/SD write upgrade
  - bounded ACE wait timeout with error completion
  - refill-loop guard

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/cache_ctrl_coherent_if.sv | 27 ++
 rtl/cache_ace_wait_timer.sv | 33 +++
 rtl/cache_ctrl_coherent.sv | 205 ++++++++++++++++++++
 tb/tb_cache_ctrl_coherent.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the coherent cache controller.
// Line-state encoding: UC=0, UD=1, SC=2, SD=3, I=4. Codes 5-7 are illegal.
package cache_pkg;

  localparam int WIDTH_STATE = 3;

  typedef enum logic [WIDTH_STATE-1:0] {
    LS_UC = 3'd0,
    LS_UD = 3'd1,
    LS_SC = 3'd2,
    LS_SD = 3'd3,
    LS_I  = 3'd4
  } line_state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_NOP   = 2'b10
  } cpu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_UPGRADE,
    ST_DONE,
    ST_ERROR
  } ctrl_state_t;

  // Illegal codes from the datapath are handled exactly like an invalid line.
  function automatic line_state_t legalize(input logic [WIDTH_STATE-1:0] code);
    return (code > WIDTH_STATE'(4)) ? LS_I : line_state_t'(code);
  endfunction

  function automatic logic is_dirty(input line_state_t ls);
    return (ls == LS_UD) || (ls == LS_SD);
  endfunction

endpackage

// File: rtl/cache_ctrl_coherent_if.sv
// CPU-side request/response bundle of the coherent cache controller.
// master = CPU (issues requests), slave = controller (accepts and completes).
interface cache_ctrl_coherent_if;

  logic       cpu_req_valid;
  logic [1:0] cpu_req_op;
  logic       cpu_req_ready;
  logic       cache_complete;
  logic       cache_error;

  modport master (
    output cpu_req_valid,
    output cpu_req_op,
    input  cpu_req_ready,
    input  cache_complete,
    input  cache_error
  );

  modport slave (
    input  cpu_req_valid,
    input  cpu_req_op,
    output cpu_req_ready,
    output cache_complete,
    output cache_error
  );

endinterface

// File: rtl/cache_ace_wait_timer.sv
// Counts cycles spent waiting on ace_ready within one ACE phase and flags
// a timeout when TIMEOUT_CYCLES waiting cycles pass without ace_ready.
// TIMEOUT_CYCLES = 0 disables the timeout.
module cache_ace_wait_timer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  input  logic ace_ready,
  output logic expired
);

  logic [CNT_WIDTH-1:0] cnt;

  // ace_ready in the limit cycle keeps expired low, so completion wins.
  assign expired = (TIMEOUT_CYCLES != 0) && waiting && !ace_ready &&
                   (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Wait counter: restarts on every controller state change.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset || clear) begin
      cnt <= '0;
    end else if (waiting && !ace_ready && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl_coherent.sv
// Coherent single-line cache controller between the CPU request port, the
// tag/state datapath and the ACE controller. Handles hits, SC/SD write
// upgrades, dirty-victim writeback, refill with re-lookup, a refill-loop
// guard and a bounded ACE wait.
// Optional statistics counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl_coherent
  import cache_pkg::*;
#(
  parameter int WIDTH_STATE    = cache_pkg::WIDTH_STATE,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
`ifdef CACHE_CTRL_STATS_EN
  , parameter int STAT_WIDTH   = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_ctrl_coherent_if.slave   cpu,
  input  logic                   cache_hit,
  input  logic                   cache_miss,
  input  logic [WIDTH_STATE-1:0] line_state,
  input  logic                   ace_ready,
  output logic                   read_req,
  output logic                   write_req,
  output logic                   invalid_req,
  output logic                   write_from_cpu,
  output logic                   write_from_interconnect,
  output logic [WIDTH_STATE-1:0] new_state,
  output logic                   new_state_we
`ifdef CACHE_CTRL_STATS_EN
  , output logic [STAT_WIDTH-1:0] stat_hits
  , output logic [STAT_WIDTH-1:0] stat_misses
  , output logic [STAT_WIDTH-1:0] stat_errors
`endif
);

  ctrl_state_t state_q, state_d;
  cpu_op_t     op_q;
  logic        refilled_q;
  logic        refill_set;
  line_state_t ls;
  line_state_t ns;
  logic        lk_hit;
  logic        waiting;
  logic        timeout;
  logic        ready, complete, error;

  assign ls     = legalize(line_state);
  // A lookup is a usable hit only if miss is quiet and the line is valid.
  assign lk_hit = cache_hit && !cache_miss && (ls != LS_I);
  assign waiting = (state_q == ST_WRITEBACK) || (state_q == ST_ALLOCATE) ||
                   (state_q == ST_UPGRADE);

  cache_ace_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_d != state_q),
    .waiting   (waiting),
    .ace_ready (ace_ready),
    .expired   (timeout)
  );

  // Next-state and output decode; reset forces the idle output pattern.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d                 = state_q;
    ready                   = 1'b0;
    read_req                = 1'b0;
    write_req               = 1'b0;
    invalid_req             = 1'b0;
    write_from_cpu          = 1'b0;
    write_from_interconnect = 1'b0;
    ns                      = LS_I;
    new_state_we            = 1'b0;
    complete                = 1'b0;
    error                   = 1'b0;
    refill_set              = 1'b0;
    if (reset) begin
      ready = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready = 1'b1;
          if (cpu.cpu_req_valid &&
              (cpu.cpu_req_op == OP_READ || cpu.cpu_req_op == OP_WRITE)) begin
            state_d = ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (cache_hit || cache_miss) begin
            if (lk_hit && op_q == OP_READ) begin
              state_d = ST_DONE;
            end else if (lk_hit && (ls == LS_UC || ls == LS_UD)) begin
              write_from_cpu = 1'b1;
              ns             = LS_UD;
              new_state_we   = 1'b1;
              state_d        = ST_DONE;
            end else if (lk_hit) begin
              state_d = ST_UPGRADE;
            end else if (refilled_q) begin
              state_d = ST_ERROR;
            end else if (is_dirty(ls)) begin
              state_d = ST_WRITEBACK;
            end else begin
              state_d = ST_ALLOCATE;
            end
          end
        end
        ST_WRITEBACK: begin
          write_req = 1'b1;
          if (ace_ready) begin
            ns           = LS_I;
            new_state_we = 1'b1;
            state_d      = ST_ALLOCATE;
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        ST_ALLOCATE: begin
          read_req = 1'b1;
          if (ace_ready) begin
            write_from_interconnect = 1'b1;
            ns                      = (op_q == OP_WRITE) ? LS_UC : LS_SC;
            new_state_we            = 1'b1;
            refill_set              = 1'b1;
            state_d                 = ST_LOOKUP;
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        ST_UPGRADE: begin
          invalid_req = 1'b1;
          if (ace_ready) begin
            write_from_cpu = 1'b1;
            ns             = LS_UD;
            new_state_we   = 1'b1;
            state_d        = ST_DONE;
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        ST_DONE: begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_ERROR: begin
          complete = 1'b1;
          error    = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign new_state          = ns;
  assign cpu.cpu_req_ready  = ready;
  assign cpu.cache_complete = complete;
  assign cpu.cache_error    = error;

  // FSM state, latched opcode and refill-loop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      refilled_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d == ST_LOOKUP) begin
        op_q       <= cpu_op_t'(cpu.cpu_req_op);
        refilled_q <= 1'b0;
      end else if (refill_set) begin
        refilled_q <= 1'b1;
      end
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic hit_ev, miss_ev, err_ev;

  // LOOKUP leaving for DONE/UPGRADE is a hit; for WRITEBACK/ALLOCATE a miss.
  assign hit_ev  = (state_q == ST_LOOKUP) && !refilled_q &&
                   (state_d == ST_DONE || state_d == ST_UPGRADE);
  assign miss_ev = (state_q == ST_LOOKUP) &&
                   (state_d == ST_WRITEBACK || state_d == ST_ALLOCATE);
  assign err_ev  = (state_d == ST_ERROR) && (state_q != ST_ERROR);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_errors <= '0;
    end else begin
      if (hit_ev && stat_hits != '1)    stat_hits   <= stat_hits + 1'b1;
      if (miss_ev && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      if (err_ev && stat_errors != '1)  stat_errors <= stat_errors + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_coherent.sv
// Self-checking bench for cache_ctrl_coherent: directed scenarios followed by
// randomized transactions. Each transaction is described as a scenario
// (op, lookup results, ACE delays, post-refill lookup) and the expected
// per-cycle outputs are derived from the controller's transaction rules.
module tb_cache_ctrl_coherent;

  localparam int TMO = 8;

  // Expected-output vector bits.
  localparam logic [8:0] E_RDY = 9'h100, E_RD  = 9'h080, E_WR  = 9'h040;
  localparam logic [8:0] E_INV = 9'h020, E_WFC = 9'h010, E_WFI = 9'h008;
  localparam logic [8:0] E_WE  = 9'h004, E_CMP = 9'h002, E_ERR = 9'h001;

  typedef struct {
    int op;
    int stall;
    bit hit1;
    bit miss1;
    int ls1;
    int d_wb;
    int d_alloc;
    int d_upg;
    int relook;  // 0: hit with refilled state, 1: miss again, 2: hit on I
  } scen_t;

  typedef enum {P_LOOKUP, P_WB, P_ALLOC, P_UPG, P_DONE, P_ERR, P_END} phase_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cache_hit, cache_miss, ace_ready;
  logic [2:0] line_state;
  logic       read_req, write_req, invalid_req;
  logic       write_from_cpu, write_from_interconnect;
  logic [2:0] new_state;
  logic       new_state_we;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_errors;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int m_hits = 0, m_misses = 0, m_errors = 0;

  cache_ctrl_coherent_if cif ();

  cache_ctrl_coherent #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cpu                     (cif),
    .cache_hit               (cache_hit),
    .cache_miss              (cache_miss),
    .line_state              (line_state),
    .ace_ready               (ace_ready),
    .read_req                (read_req),
    .write_req               (write_req),
    .invalid_req             (invalid_req),
    .write_from_cpu          (write_from_cpu),
    .write_from_interconnect (write_from_interconnect),
    .new_state               (new_state),
    .new_state_we            (new_state_we)
`ifdef CACHE_CTRL_STATS_EN
    , .stat_hits             (stat_hits)
    , .stat_misses           (stat_misses)
    , .stat_errors           (stat_errors)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] obs_vec;
  assign obs_vec = {cif.cpu_req_ready, read_req, write_req, invalid_req,
                    write_from_cpu, write_from_interconnect, new_state_we,
                    cif.cache_complete, cif.cache_error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; sample mid-cycle, then step.
  task automatic cyc(input string tag, input logic [8:0] exp, input bit chk_ns,
                     input logic [2:0] exp_ns);
    @(negedge clk);
    check(tag, 32'(obs_vec), 32'(exp));
    if (chk_ns) check({tag, "_new_state"}, 32'(new_state), 32'(exp_ns));
    @(posedge clk);
    #1;
  endtask

  // One ACE phase: request held until ace_ready (after d cycles) or timeout.
  task automatic ace_phase(input string tag, input logic [8:0] req, input int d,
                           input logic [8:0] done_bits, input logic [2:0] ns,
                           output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= d; k++) begin
      ace_ready = (k == d);
      if (k == d) begin
        cyc({tag, "_ready"}, req | done_bits, 1'b1, ns);
        ok = 1'b1;
        break;
      end else if (k == TMO - 1) begin
        cyc({tag, "_last_wait"}, req, 1'b0, 3'd0);
        break;
      end else begin
        cyc({tag, "_wait"}, req, 1'b0, 3'd0);
      end
    end
    ace_ready = 1'b0;
  endtask

  function automatic int pick_delay();
    int tbl[9] = '{0, 0, 1, 2, 3, 5, 7, 8, 12};
    return tbl[$urandom_range(0, 8)];
  endfunction

  function automatic scen_t mk(input int op, input int stall, input bit h, input bit m,
                               input int ls, input int dwb, input int dal, input int dup,
                               input int relook);
    scen_t s;
    s.op = op; s.stall = stall; s.hit1 = h; s.miss1 = m; s.ls1 = ls;
    s.d_wb = dwb; s.d_alloc = dal; s.d_upg = dup; s.relook = relook;
    return s;
  endfunction

  function automatic scen_t rand_scen();
    int r, hm, rl, op, ls;
    r  = $urandom_range(0, 19);
    op = (r < 8) ? 0 : (r < 17) ? 1 : (r == 17) ? 2 : 3;
    hm = $urandom_range(0, 9);
    ls = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
    rl = $urandom_range(0, 9);
    return mk(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              (hm < 5) || (hm == 9), hm >= 5, ls,
              pick_delay(), pick_delay(), pick_delay(),
              (rl < 7) ? 0 : (rl < 9) ? 1 : 2);
  endfunction

  task automatic run_txn(input scen_t s);
    phase_t ph;
    bit     refilled, ok, h, m, real_hit;
    int     ls, eff, wst, nstall;
    logic [8:0] exp;
    logic [2:0] exp_ns;
    bit     chk;

    cif.cpu_req_valid = 1'b1;
    cif.cpu_req_op    = 2'(s.op);
    cyc("idle_ready", E_RDY, 1'b0, 3'd0);
    if (s.op > 1) begin
      cif.cpu_req_valid = 1'b0;
      cyc("nop_stays_idle", E_RDY, 1'b0, 3'd0);
      return;
    end
    // Requests offered while busy must be ignored and must not alter the op.
    cif.cpu_req_valid = 1'($urandom_range(0, 1));
    cif.cpu_req_op    = 2'($urandom_range(0, 3));

    wst      = (s.op == 1) ? 0 : 2;
    refilled = 1'b0;
    ph       = P_LOOKUP;
    while (ph != P_END) begin
      case (ph)
        P_LOOKUP: begin
          nstall = s.stall;
          cache_hit = 1'b0; cache_miss = 1'b0;
          line_state = 3'($urandom_range(0, 7));
          repeat (nstall) cyc("lookup_stall", 9'd0, 1'b0, 3'd0);
          if (!refilled) begin
            h = s.hit1; m = s.miss1; ls = s.ls1;
          end else begin
            h  = (s.relook != 1);
            m  = (s.relook == 1);
            ls = (s.relook == 2) ? 4 : wst;
          end
          cache_hit = h; cache_miss = m; line_state = 3'(ls);
          eff      = (ls > 4) ? 4 : ls;
          real_hit = h && !m && (eff != 4);
          exp = 9'd0; chk = 1'b0; exp_ns = 3'd0;
          if (real_hit && s.op == 0) begin
            ph = P_DONE;
            if (!refilled) m_hits++;
          end else if (real_hit && eff <= 1) begin
            exp = E_WFC | E_WE; chk = 1'b1; exp_ns = 3'd1;
            ph = P_DONE;
            if (!refilled) m_hits++;
          end else if (real_hit) begin
            ph = P_UPG;
            if (!refilled) m_hits++;
          end else if (refilled) begin
            ph = P_ERR;
            m_errors++;
          end else if (eff == 1 || eff == 3) begin
            ph = P_WB;
            m_misses++;
          end else begin
            ph = P_ALLOC;
            m_misses++;
          end
          cyc("lookup", exp, chk, exp_ns);
          cache_hit = 1'b0; cache_miss = 1'b0;
        end
        P_WB: begin
          ace_phase("writeback", E_WR, s.d_wb, E_WE, 3'd4, ok);
          ph = ok ? P_ALLOC : P_ERR;
          if (!ok) m_errors++;
        end
        P_ALLOC: begin
          ace_phase("allocate", E_RD, s.d_alloc, E_WFI | E_WE, 3'(wst), ok);
          if (ok) begin
            refilled = 1'b1;
            ph = P_LOOKUP;
          end else begin
            ph = P_ERR;
            m_errors++;
          end
        end
        P_UPG: begin
          ace_phase("upgrade", E_INV, s.d_upg, E_WFC | E_WE, 3'd1, ok);
          ph = ok ? P_DONE : P_ERR;
          if (!ok) m_errors++;
        end
        P_DONE: begin
          cyc("complete", E_CMP, 1'b0, 3'd0);
          ph = P_END;
        end
        P_ERR: begin
          cyc("error_complete", E_CMP | E_ERR, 1'b0, 3'd0);
          ph = P_END;
        end
        default: ph = P_END;
      endcase
    end
    cif.cpu_req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cif.cpu_req_valid = 1'b0; cif.cpu_req_op = 2'b00;
    cache_hit = 1'b0; cache_miss = 1'b0; line_state = 3'd4; ace_ready = 1'b0;
    @(posedge clk); #1;
    cyc("reset_outputs", E_RDY, 1'b1, 3'd4);
    reset = 1'b0;
    cyc("post_reset_idle", E_RDY, 1'b1, 3'd4);

    // Synchronous reset during ALLOCATE, with ace_ready also high.
    cif.cpu_req_valid = 1'b1; cif.cpu_req_op = 2'b00;
    cyc("rst_accept", E_RDY, 1'b0, 3'd0);
    cif.cpu_req_valid = 1'b0;
    cache_miss = 1'b1; line_state = 3'd2;
    cyc("rst_lookup_miss", 9'd0, 1'b0, 3'd0);
    cache_miss = 1'b0;
    cyc("rst_allocate", E_RD, 1'b0, 3'd0);
    reset = 1'b1; ace_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ace_ready = 1'b0;
    cyc("rst_after_edge", E_RDY, 1'b1, 3'd4);
    cyc("rst_still_idle", E_RDY, 1'b0, 3'd0);
    m_hits = 0; m_misses = 0; m_errors = 0;

    // Directed scenarios.
    run_txn(mk(0, 0, 1, 0, 2, 0, 0, 0, 0));   // read hit on SC
    run_txn(mk(1, 0, 1, 0, 2, 0, 0, 3, 0));   // write hit SC, upgrade after 3
    run_txn(mk(0, 1, 0, 1, 1, 2, 1, 0, 0));   // read miss, UD victim
    run_txn(mk(0, 0, 0, 1, 2, 0, 20, 0, 0));  // refill timeout
    run_txn(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));   // refill-loop guard
    run_txn(mk(3, 0, 0, 0, 0, 0, 0, 0, 0));   // op 11 ignored
    run_txn(mk(1, 0, 1, 0, 3, 0, 0, 7, 0));   // ready on the last wait cycle
    run_txn(mk(1, 0, 1, 0, 3, 0, 0, 8, 0));   // upgrade timeout
    run_txn(mk(0, 0, 1, 1, 1, 8, 0, 0, 0));   // hit+miss as miss, WB timeout
    run_txn(mk(0, 0, 1, 0, 6, 0, 0, 0, 0));   // illegal code treated as I
    run_txn(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));   // write hit on UD

    for (int t = 0; t < 300; t++) run_txn(rand_scen());

`ifdef CACHE_CTRL_STATS_EN
    check("stat_hits", stat_hits, 32'(m_hits));
    check("stat_misses", stat_misses, 32'(m_misses));
    check("stat_errors", stat_errors, 32'(m_errors));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
